// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the float datapath stages.
// Holds field widths, special-value constants and the adder state encoding.
package fp_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational 28-bit leading-zero counter.
// Ports: value (28-bit input), count (5-bit number of leading zeros, 28 for 0).
module fp_lzc (
  input  logic [27:0] value,
  input  logic        unused_tie,
  output logic [4:0]  count
);

  // Scan LSB to MSB so the highest set bit determines the final count.
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end

  logic unused_ok;
  assign unused_ok = unused_tie;

endmodule

// File: rtl/fpadd_seq.sv
// Sequential binary32 adder: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Ports: clk, rst (sync, active-high); a, b, in_valid, in_ready (input side);
//        result, out_valid, out_ready (output side). Subnormals flush to zero,
//        rounding is nearest-even. out_valid is raised from the DONE state,
//        one edge after the packed result is registered.
module fpadd_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  state_t      state;
  logic [31:0] a_r, b_r;
  logic        sign_r, sub_r, byp_r;
  logic [31:0] byp_val_r;
  logic [7:0]  exp_r;
  logic [23:0] sig_big_r;
  logic [26:0] sig_sml_r;
  logic [27:0] sum_r;

  assign in_ready = (state == IDLE);

  // ALIGN: unpack, classify, order by magnitude and shift the smaller operand.
  logic [7:0]  ea, eb, exp_big, exp_sml, diff;
  logic        za, zb, nan_a, nan_b, inf_a, inf_b, a_big;
  logic [30:0] key_a, key_b;
  logic [23:0] sig_a, sig_b, sig_big, sig_sml;
  logic [26:0] ext, al_sml, lost_mask;
  logic        byp;
  logic [31:0] byp_val;

  always_comb begin
    ea      = a_r[30:23];
    eb      = b_r[30:23];
    za      = (ea == 8'd0);
    zb      = (eb == 8'd0);
    nan_a   = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
    nan_b   = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
    inf_a   = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
    inf_b   = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
    sig_a   = za ? 24'd0 : {1'b1, a_r[22:0]};
    sig_b   = zb ? 24'd0 : {1'b1, b_r[22:0]};
    key_a   = za ? 31'd0 : a_r[30:0];
    key_b   = zb ? 31'd0 : b_r[30:0];
    a_big   = (key_a >= key_b);
    exp_big = a_big ? ea : eb;
    exp_sml = a_big ? eb : ea;
    sig_big = a_big ? sig_a : sig_b;
    sig_sml = a_big ? sig_b : sig_a;
    diff    = exp_big - exp_sml;
    ext     = {sig_sml, 3'b000};
    lost_mask = '0;
    if (diff >= 8'd27) begin
      al_sml    = '0;
      al_sml[0] = |sig_sml;
    end else begin
      al_sml    = ext >> diff;
      lost_mask = (27'd1 << diff) - 27'd1;
      al_sml[0] = al_sml[0] | (|(ext & lost_mask));
    end

    byp     = 1'b1;
    byp_val = QNAN;
    if (nan_a || nan_b)                          byp_val = QNAN;
    else if (inf_a && inf_b && (a_r[31] != b_r[31])) byp_val = QNAN;
    else if (inf_a)                              byp_val = a_r[31] ? NEG_INF : POS_INF;
    else if (inf_b)                              byp_val = b_r[31] ? NEG_INF : POS_INF;
    else if (za && zb)                           byp_val = {a_r[31] & b_r[31], 31'd0};
    else                                         byp = 1'b0;
  end

  // NORM: normalize via leading-zero count, round nearest-even, pack.
  logic [4:0]  lz;
  logic [27:0] shifted;
  logic [26:0] m27;
  logic [9:0]  e_u, e_fin;
  logic        rnd_up;
  logic [24:0] rounded;
  logic [22:0] frac;
  logic [31:0] packed_res;

  fp_lzc u_lzc (
    .value      (sum_r),
    .unused_tie (1'b0),
    .count      (lz)
  );

  always_comb begin
    // Carry case gives lz=0, so one path covers both the right and left shift.
    shifted = sum_r << lz;
    m27     = {shifted[27:2], |shifted[1:0]};
    e_u     = {2'b00, exp_r} + 10'd1 - {5'b00000, lz};
    rnd_up  = m27[2] & (m27[1] | m27[0] | m27[3]);
    rounded = {1'b0, m27[26:3]} + 25'(rnd_up);
    frac    = rounded[24] ? rounded[23:1] : rounded[22:0];
    e_fin   = e_u + 10'(rounded[24]);
    if (byp_r)                            packed_res = byp_val_r;
    else if (sum_r == 28'd0)              packed_res = 32'd0;
    else if (e_u[9] || (e_u == 10'd0))    packed_res = {sign_r, 31'd0};
    else if (e_fin >= 10'd255)            packed_res = {sign_r, 8'hFF, 23'd0};
    else                                  packed_res = {sign_r, e_fin[7:0], frac};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      sub_r     <= 1'b0;
      byp_r     <= 1'b0;
      byp_val_r <= '0;
      exp_r     <= '0;
      sig_big_r <= '0;
      sig_sml_r <= '0;
      sum_r     <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          state <= ALIGN;
        end
        ALIGN: begin
          sign_r    <= a_big ? a_r[31] : b_r[31];
          sub_r     <= a_r[31] ^ b_r[31];
          exp_r     <= exp_big;
          sig_big_r <= sig_big;
          sig_sml_r <= al_sml;
          byp_r     <= byp;
          byp_val_r <= byp_val;
          state     <= ADD;
        end
        ADD: begin
          sum_r <= sub_r ? ({1'b0, sig_big_r, 3'b000} - {1'b0, sig_sml_r})
                         : ({1'b0, sig_big_r, 3'b000} + {1'b0, sig_sml_r});
          state <= NORM;
        end
        NORM: begin
          result <= packed_res;
          state  <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
